// File: rtl/pixel_pack_pkg.sv
// Shared constants, phase encoding and line-geometry helpers for the
// 24-bit pixel to 32-bit AXI4-Stream packer.
// Optional feature macro: PACK_TLAST_EN (see pixel_to_axis_packer.sv).
package pixel_pack_pkg;

    localparam int unsigned PIXEL_WIDTH      = 24;
    localparam int unsigned AXIS_TDATA_WIDTH = 32;

    // Accepted pixel count mod 4
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    // 4 pixels pack into 3 words
    function automatic int unsigned words_per_line(input int unsigned line_pixels);
        return (line_pixels * 3) / 4;
    endfunction

    function automatic int unsigned word_cnt_width(input int unsigned line_pixels);
        int unsigned wpl;
        wpl = words_per_line(line_pixels);
        return (wpl > 1) ? $clog2(wpl) : 1;
    endfunction

endpackage

// File: rtl/pixel_to_axis_packer_if.sv
// Bus bundle for pixel_to_axis_packer: the 24-bit pixel input handshake and
// the 32-bit AXIS master output.
//   master : packer view (consumes pixels, drives AXIS)
//   slave  : environment view (drives pixels, consumes AXIS)
interface pixel_to_axis_packer_if;
    import pixel_pack_pkg::*;

    logic [PIXEL_WIDTH-1:0]      pix_data;
    logic                        pix_valid;
    logic                        pix_ready;
    logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;

    modport master (
        input  pix_data, pix_valid, m_axis_tready,
        output pix_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output pix_data, pix_valid, m_axis_tready,
        input  pix_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/pixel_pack_out_reg.sv
// AXIS output holding register. Loads a word (and its tlast) on load, keeps
// tdata/tlast stable while stalled, clears tvalid after a handshake unless a
// new word loads in the same cycle.
//   clk, rst_n          : clock, async active-low reset
//   load/load_data/last : new word from the packer (only when can_load)
//   tready              : downstream ready
//   tdata/tvalid/tlast  : registered AXIS outputs
//   can_load            : register is empty or draining this cycle
module pixel_pack_out_reg
    import pixel_pack_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [AXIS_TDATA_WIDTH-1:0] load_data,
    input  logic                        load_last,
    input  logic                        tready,
    output logic [AXIS_TDATA_WIDTH-1:0] tdata,
    output logic                        tvalid,
    output logic                        tlast,
    output logic                        can_load
);

    logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    always_comb begin
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q && !tready;
        if (load) begin
            tdata_d  = load_data;
            tlast_d  = load_last;
            tvalid_d = 1'b1;
        end
    end

    assign can_load = !tvalid_q || tready;
    assign tdata    = tdata_q;
    assign tvalid   = tvalid_q;
    assign tlast    = tlast_q;

endmodule

// File: rtl/pixel_to_axis_packer.sv
// Packs 24-bit RGB888 pixels into 32-bit AXIS words, 4 pixels -> 3 words,
// no padding, byte0 of pixel 0 in the LSB of word 0.
//   clk    : clock
//   rst_n  : async active-low reset
//   bus    : pixel_to_axis_packer_if.master (pix_* input, m_axis_* output)
// Optional: define PACK_TLAST_EN to drive m_axis_tlast on the last word of
// each LINE_PIXELS line; otherwise tlast is constant 0.
module pixel_to_axis_packer
    import pixel_pack_pkg::*;
#(
    parameter int unsigned LINE_PIXELS = 3840
) (
    input logic                    clk,
    input logic                    rst_n,
    pixel_to_axis_packer_if.master bus
);

    if ((LINE_PIXELS % 4) != 0) begin : g_bad_line_pixels
        $error("LINE_PIXELS must be a multiple of 4");
    end

    phase_e                  phase_q, phase_d;
    logic [PIXEL_WIDTH-1:0]  res_q, res_d;

    logic                        accept;
    logic                        word_load;
    logic [AXIS_TDATA_WIDTH-1:0] word_data;
    logic                        load_last;
    logic                        can_load;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= P0;
            res_q   <= '0;
        end else begin
            phase_q <= phase_d;
            res_q   <= res_d;
        end
    end

    // Next state: residue keeps the bytes not yet emitted
    always_comb begin
        phase_d = phase_q;
        res_d   = res_q;
        if (accept) begin
            unique case (phase_q)
                P0: begin
                    res_d   = bus.pix_data;
                    phase_d = P1;
                end
                P1: begin
                    res_d[15:0] = bus.pix_data[23:8];
                    phase_d     = P2;
                end
                P2: begin
                    res_d[7:0] = bus.pix_data[23:16];
                    phase_d    = P3;
                end
                P3: phase_d = P0;
            endcase
        end
    end

    // Outputs: P0 emits nothing so it never needs the output register
    always_comb begin
        bus.pix_ready = (phase_q == P0) || can_load;
        accept        = bus.pix_valid && bus.pix_ready;
        word_load     = accept && (phase_q != P0);
        unique case (phase_q)
            P1:      word_data = {bus.pix_data[7:0], res_q};
            P2:      word_data = {bus.pix_data[15:0], res_q[15:0]};
            P3:      word_data = {bus.pix_data, res_q[7:0]};
            default: word_data = '0;
        endcase
    end

`ifdef PACK_TLAST_EN
    localparam int unsigned WPL = words_per_line(LINE_PIXELS);
    localparam int unsigned CW  = word_cnt_width(LINE_PIXELS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (word_load) cnt_d = (cnt_q == CW'(WPL - 1)) ? '0 : cnt_q + 1'b1;
    end

    assign load_last = (cnt_q == CW'(WPL - 1));
`else
    assign load_last = 1'b0;
`endif

    pixel_pack_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (word_load),
        .load_data (word_data),
        .load_last (load_last),
        .tready    (bus.m_axis_tready),
        .tdata     (bus.m_axis_tdata),
        .tvalid    (bus.m_axis_tvalid),
        .tlast     (bus.m_axis_tlast),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_pixel_to_axis_packer.sv
module tb_pixel_to_axis_packer;
    import pixel_pack_pkg::*;

`ifdef PACK_TLAST_EN
    localparam bit TL_EN = 1'b1;
`else
    localparam bit TL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pixel_to_axis_packer_if bus ();

    pixel_to_axis_packer #(.LINE_PIXELS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int timeouts = 0;
    int stab_err = 0;

    logic [31:0] out_q[$];
    bit          last_q[$];

    logic [31:0] prev_data;
    bit          prev_stall = 1'b0;

    // Records every output handshake that will happen at the next posedge,
    // and flags any change of a stalled word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data))
                stab_err++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                out_q.push_back(bus.m_axis_tdata);
                last_q.push_back(bus.m_axis_tlast);
            end
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference packing: pixel bytes form a little-endian byte stream
    function automatic logic [31:0] exp_word(input logic [23:0] px[$], input int k);
        logic [31:0] w;
        logic [23:0] p;
        int j;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            j = 4 * k + b;
            p = px[j / 3];
            w[8*b +: 8] = p[8*(j % 3) +: 8];
        end
        return w;
    endfunction

    task automatic do_reset();
        bus.pix_valid     = 1'b0;
        bus.pix_data      = '0;
        bus.m_axis_tready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_q.delete();
        last_q.delete();
    endtask

    // Presents one pixel and returns #1 after the edge that accepts it; valid stays high
    task automatic send_pixel(input logic [23:0] p);
        int n;
        bus.pix_data  = p;
        bus.pix_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeouts++;
        @(posedge clk); #1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [23:0] px4[$]  = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    logic [31:0] exp4[3] = '{32'h66112233, 32'h88994455, 32'hAABBCC77};

    task automatic test_reset();
        bus.pix_valid     = 1'b0;
        bus.pix_data      = '0;
        bus.m_axis_tready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        total++; if (bus.m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", bus.m_axis_tvalid); else passed++;
        total++; if (bus.m_axis_tdata !== 32'h0) $display("FAIL reset_tdata got %h want 0", bus.m_axis_tdata); else passed++;
        total++; if (bus.m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", bus.m_axis_tlast); else passed++;
        total++; if (bus.pix_ready !== 1'b1) $display("FAIL reset_pix_ready got %b want 1", bus.pix_ready); else passed++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.pix_data  = px4[i];
            bus.pix_valid = 1'b1;
            @(negedge clk);
            total++; if (bus.pix_ready !== 1'b1) $display("FAIL basic_ready[%0d] got %b want 1", i, bus.pix_ready); else passed++;
            @(posedge clk); #1;
            total++; if (bus.m_axis_tvalid !== (i > 0)) $display("FAIL basic_tvalid[%0d] got %b want %b", i, bus.m_axis_tvalid, i > 0); else passed++;
            if (i > 0) begin
                total++; if (bus.m_axis_tdata !== exp4[i-1]) $display("FAIL basic_tdata[%0d] got %h want %h", i, bus.m_axis_tdata, exp4[i-1]); else passed++;
            end
        end
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) $display("FAIL basic_idle_tvalid got %b want 0", bus.m_axis_tvalid); else passed++;
    endtask

    task automatic test_stream400();
        logic [23:0] px[$];
        int drops, mism;
        do_reset();
        drops = 0; mism = 0;
        for (int i = 0; i < 400; i++) begin
            px.push_back(24'(i * 32'h00010203 + 32'h000A0B0C));
            bus.pix_data  = px[i];
            bus.pix_valid = 1'b1;
            @(negedge clk);
            if (bus.pix_ready !== 1'b1) drops++;
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        wait_words(300, 50);
        total++; if (drops != 0) $display("FAIL stream_ready_drops got %0d want 0", drops); else passed++;
        total++; if (out_q.size() != 300) $display("FAIL stream_word_count got %0d want 300", out_q.size()); else passed++;
        for (int k = 0; k < out_q.size() && k < 300; k++)
            if (out_q[k] !== exp_word(px, k)) mism++;
        total++; if (mism != 0) $display("FAIL stream_data mismatches got %0d want 0", mism); else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        bad = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = px4[0]; @(posedge clk); #1;
        bus.pix_data  = px4[1]; @(posedge clk); #1;
        bus.m_axis_tready = 1'b0;
        bus.pix_data      = px4[2];
        repeat (5) begin
            @(negedge clk);
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h66112233 || bus.pix_ready !== 1'b0) bad++;
        end
        total++; if (bus.m_axis_tdata !== 32'h66112233) $display("FAIL stall_tdata got %h want 66112233", bus.m_axis_tdata); else passed++;
        total++; if (bad != 0) $display("FAIL stall_hold bad cycles got %0d want 0", bad); else passed++;
        @(posedge clk); #1;
        bus.m_axis_tready = 1'b1;
        @(posedge clk); #1;
        bus.pix_data = px4[3];
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        wait_words(3, 50);
        total++; if (out_q.size() != 3) $display("FAIL stall_word_count got %0d want 3", out_q.size()); else passed++;
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            total++; if (out_q[k] !== exp4[k]) $display("FAIL stall_word[%0d] got %h want %h", k, out_q[k], exp4[k]); else passed++;
        end
    endtask

    task automatic test_throttle();
        logic [23:0] px[$];
        int mism;
        bit done;
        do_reset();
        mism = 0; done = 1'b0; stab_err = 0; timeouts = 0;
        for (int i = 0; i < 4000; i++) px.push_back(24'($urandom));
        fork
            begin
                for (int i = 0; i < 4000; i++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        bus.pix_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send_pixel(px[i]);
                end
                bus.pix_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.m_axis_tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.m_axis_tready = 1'b1;
            end
        join
        wait_words(3000, 200);
        total++; if (timeouts != 0) $display("FAIL throttle_timeouts got %0d want 0", timeouts); else passed++;
        total++; if (out_q.size() != 3000) $display("FAIL throttle_word_count got %0d want 3000", out_q.size()); else passed++;
        for (int k = 0; k < out_q.size() && k < 3000; k++)
            if (out_q[k] !== exp_word(px, k)) mism++;
        total++; if (mism != 0) $display("FAIL throttle_data mismatches got %0d want 0", mism); else passed++;
        total++; if (stab_err != 0) $display("FAIL throttle_stability violations got %0d want 0", stab_err); else passed++;
    endtask

    task automatic test_tlast();
        int bad;
        bit want;
        do_reset();
        bad = 0;
        for (int i = 0; i < 16; i++) send_pixel(24'(32'h100000 + i));
        bus.pix_valid = 1'b0;
        wait_words(12, 50);
        total++; if (out_q.size() != 12) $display("FAIL tlast_word_count got %0d want 12", out_q.size()); else passed++;
        for (int k = 0; k < last_q.size(); k++) begin
            want = TL_EN && ((k % 6) == 5);
            if (last_q[k] !== want) begin
                bad++;
                $display("FAIL tlast_word[%0d] got %b want %b", k, last_q[k], want);
            end
        end
        total++; if (bad != 0) $display("FAIL tlast_flags wrong got %0d want 0", bad); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m_axis_tready = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = px4[0]; @(posedge clk); #1;
        bus.pix_data  = px4[1]; @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        total++; if (bus.m_axis_tvalid !== 1'b1) $display("FAIL midrst_pending got %b want 1", bus.m_axis_tvalid); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.m_axis_tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", bus.m_axis_tvalid); else passed++;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        bus.m_axis_tready = 1'b1;
        @(posedge clk); #1;
        out_q.delete();
        last_q.delete();
        for (int i = 0; i < 4; i++) send_pixel(px4[i]);
        bus.pix_valid = 1'b0;
        wait_words(3, 50);
        total++; if (out_q.size() != 3) $display("FAIL midrst_word_count got %0d want 3", out_q.size()); else passed++;
        for (int k = 0; k < 3 && k < out_q.size(); k++) begin
            total++; if (out_q[k] !== exp4[k]) $display("FAIL midrst_word[%0d] got %h want %h", k, out_q[k], exp4[k]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream400();
        test_backpressure();
        test_throttle();
        test_tlast();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
